// File: rtl/rf_pkg.sv
// Shared constants, address-width helper and address type for the
// multi-port register file.
package rf_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_NUM_RD   = 2;

  // Address width for a register count; never narrower than one bit.
  function automatic int rf_aw(input int n);
    if (n > 2) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

  localparam int RF_AW = rf_aw(RF_NUM_REGS);

  typedef logic [RF_AW-1:0] rf_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits with reserve/release/flush priority and the
// per-read-port busy lookup, including same-cycle release bypass.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int NUM_REGS = RF_NUM_REGS,
  parameter  int NUM_RD   = RF_NUM_RD,
  parameter  int BYPASS   = 1,
  localparam int AW       = rf_aw(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  input  logic                 we,
  input  logic [AW-1:0]        dst_addr,
  input  logic [NUM_RD*AW-1:0] p_addr,
  output logic [NUM_RD-1:0]    p_busy
);

  logic [NUM_REGS-1:0] busy_r;

  // Busy array: reset, then flush, then reserve (a new producer wins), then release.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else if (flush) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r[0] <= 1'b0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (rsv_en && (rsv_addr == AW'(r))) begin
          busy_r[r] <= 1'b1;
        end else if (we && (dst_addr == AW'(r))) begin
          busy_r[r] <= 1'b0;
        end else begin
          busy_r[r] <= busy_r[r];
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_busy
    logic [AW-1:0] addr_s;
    logic          rel_hit_s;
    assign addr_s    = p_addr[i*AW +: AW];
    // A register being written this cycle already has its value on the bypass path.
    assign rel_hit_s = (BYPASS != 0) && we && (dst_addr == addr_s);
    assign p_busy[i] = busy_r[addr_s] & ~rel_hit_s;
  end

endmodule

// File: rtl/rf_mp.sv
// Parametrised register file: NUM_RD combinational read ports, one
// synchronous write port, optional write bypass and a busy scoreboard.
module rf_mp
  import rf_pkg::*;
#(
  parameter  int DATA_W   = RF_DATA_W,
  parameter  int NUM_REGS = RF_NUM_REGS,
  parameter  int NUM_RD   = RF_NUM_RD,
  parameter  int BYPASS   = 1,
  localparam int AW       = rf_aw(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     p_addr,
  input  logic [NUM_RD-1:0]        re,
  output logic [NUM_RD*DATA_W-1:0] p,
  output logic [NUM_RD-1:0]        p_busy,
  output logic                     stall,
  input  logic [AW-1:0]            dst_addr,
  input  logic [DATA_W-1:0]        dst,
  input  logic                     we,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  input  logic                     flush
);

  logic [DATA_W-1:0] mem_r [1:NUM_REGS-1];

  // Storage: register 0 has no flops, writes to it are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        mem_r[r] <= {DATA_W{1'b0}};
      end
    end else if (we && (dst_addr != {AW{1'b0}})) begin
      mem_r[dst_addr] <= dst;
    end else begin
      mem_r <= mem_r;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]     addr_s;
    logic [DATA_W-1:0] data_s;
    assign addr_s = p_addr[i*AW +: AW];

    // Read mux: hardwired zero, then same-cycle write bypass, then storage.
    always_comb begin
      data_s = {DATA_W{1'b0}};
      if (addr_s == {AW{1'b0}}) begin
        data_s = {DATA_W{1'b0}};
      end else if ((BYPASS != 0) && we && (dst_addr == addr_s)) begin
        data_s = dst;
      end else begin
        data_s = mem_r[addr_s];
      end
    end

    assign p[i*DATA_W +: DATA_W] = data_s;
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .we       (we),
    .dst_addr (dst_addr),
    .p_addr   (p_addr),
    .p_busy   (p_busy)
  );

  assign stall = |(re & p_busy);

endmodule
